// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_STOP = 2'd2
  } rx_ctrl_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok, push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  // Full FIFO still takes the push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  assign data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive byte assembly: shifts sampled bits into bytes, checks the stop bit,
// queues good bytes and keeps sticky framing/overrun flags.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        RXD,
  input  logic                        RX_Valid,
  input  logic                        RX_Load,
  input  logic                        Rx_Enable,
  output logic [7:0]                  Data,
  output logic                        Data_Valid,
  input  logic                        Data_Ready,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Count,
  output logic                        Frame_Err,
  output logic                        Overrun_Err,
  input  logic                        Err_Clr
);

  localparam int unsigned CNT_W = $clog2(UART_DATA_BITS) + 1;

  rx_ctrl_state_t            state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic                      frame_err_q, overrun_err_q;
  logic                      push, frame_evt, overrun_evt;
  logic                      fifo_full, fifo_empty;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    push      = 1'b0;
    frame_evt = 1'b0;
    if (!Rx_Enable) begin
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!RX_Load && RX_Valid) begin
            shift_d   = {RXD, shift_q[UART_DATA_BITS-1:1]};
            bit_cnt_d = CNT_W'(1);
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (RX_Load) begin
            frame_evt = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else if (RX_Valid) begin
            shift_d   = {RXD, shift_q[UART_DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(UART_DATA_BITS - 1)) state_d = WAIT_STOP;
          end
        end
        WAIT_STOP: begin
          if (RX_Load) begin
            push      = RXD;
            frame_evt = !RXD;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else if (RX_Valid) begin
            // Missing stop strobe: this bit starts the next frame.
            frame_evt = 1'b1;
            shift_d   = {RXD, shift_q[UART_DATA_BITS-1:1]};
            bit_cnt_d = CNT_W'(1);
            state_d   = SHIFT;
          end
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  assign Data_Valid  = !fifo_empty;
  assign overrun_evt = push && fifo_full && !(Data_Valid && Data_Ready);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_err_q   <= frame_evt   || (frame_err_q   && !Err_Clr);
      overrun_err_q <= overrun_evt || (overrun_err_q && !Err_Clr);
    end
  end

  assign Frame_Err   = frame_err_q;
  assign Overrun_Err = overrun_err_q;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (push),
    .push_data (shift_q),
    .pop       (Data_Ready),
    .data      (Data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (Fifo_Count)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table, directed corner sequences and
// randomized strobes against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 4;

  logic       Clk;
  logic       rst_n, rxd, rx_valid, rx_load, rx_en, ready, err_clr;
  logic [7:0] data;
  logic       data_valid, frame_err, overrun_err;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  // Reference model: collected bits of the current frame and the queued bytes.
  logic       m_bits[$];
  logic [7:0] m_q[$];
  logic       m_fe, m_oe;

  uart_rx_ctrl #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (rst_n),
    .RXD         (rxd),
    .RX_Valid    (rx_valid),
    .RX_Load     (rx_load),
    .Rx_Enable   (rx_en),
    .Data        (data),
    .Data_Valid  (data_valid),
    .Data_Ready  (ready),
    .Fifo_Count  (fifo_count),
    .Frame_Err   (frame_err),
    .Overrun_Err (overrun_err),
    .Err_Clr     (err_clr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic       pop, fe_ev, do_push;
    logic [7:0] pb;
    fe_ev   = 1'b0;
    do_push = 1'b0;
    pb      = 8'h00;
    if (!rst_n) begin
      m_bits.delete();
      m_q.delete();
      m_fe = 1'b0;
      m_oe = 1'b0;
      return;
    end
    pop = (m_q.size() > 0) && ready;
    if (!rx_en) begin
      m_bits.delete();
    end else if (rx_load) begin
      if (m_bits.size() == 8) begin
        for (int i = 0; i < 8; i++) pb[i] = m_bits[i];
        if (rxd) do_push = 1'b1;
        else fe_ev = 1'b1;
      end else if (m_bits.size() > 0) begin
        fe_ev = 1'b1;
      end
      m_bits.delete();
    end else if (rx_valid) begin
      if (m_bits.size() == 8) begin
        fe_ev = 1'b1;
        m_bits.delete();
      end
      m_bits.push_back(rxd);
    end
    if (pop) void'(m_q.pop_front());
    m_fe = fe_ev || (m_fe && !err_clr);
    if (do_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(pb);
      else m_oe = 1'b1;
    end else if (err_clr) begin
      m_oe = 1'b0;
    end
  endtask

  task automatic check_model();
    check("model_data", data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    check("model_valid", {7'd0, data_valid}, {7'd0, m_q.size() > 0});
    check("model_count", {5'd0, fifo_count}, 8'(m_q.size()));
    check("model_frame_err", {7'd0, frame_err}, {7'd0, m_fe});
    check("model_overrun_err", {7'd0, overrun_err}, {7'd0, m_oe});
  endtask

  task automatic step(input logic r, input logic v, input logic l, input logic e,
                      input logic rd, input logic c);
    rxd = r; rx_valid = v; rx_load = l; rx_en = e; ready = rd; err_clr = c;
    @(posedge Clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle(input logic rd);
    step(1'b1, 1'b0, 1'b0, 1'b1, rd, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic rd);
    for (int i = 0; i < n; i++) begin
      step(b[i], 1'b1, 1'b0, 1'b1, rd, 1'b0);
      idle(rd);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic rd);
    send_bits(b, 8, rd);
    step(stop, 1'b0, 1'b1, 1'b1, rd, 1'b0);
  endtask

  task automatic drain_expect(input logic [7:0] exp[$]);
    foreach (exp[i]) begin
      check("drain_data", data, exp[i]);
      idle(1'b1);
    end
    check("drain_empty", {7'd0, data_valid}, 8'h00);
  endtask

  typedef struct {
    logic       rxd, valid, load, rdy;
    logic [7:0] data;
    logic       dv;
    logic [2:0] cnt;
    logic       fe, oe;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] a5;
    logic [7:0] exp[$];
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) vecs[i] = '{a5[i], 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("reset_data", data, 8'h00);
    check("reset_count", {5'd0, fifo_count}, 8'h00);
    rst_n = 1'b1;

    // Vector table: byte 0xA5 received and popped.
    foreach (vecs[i]) begin
      step(vecs[i].rxd, vecs[i].valid, vecs[i].load, 1'b1, vecs[i].rdy, 1'b0);
      check($sformatf("vec%0d_data", i), data, vecs[i].data);
      check($sformatf("vec%0d_dv", i), {7'd0, data_valid}, {7'd0, vecs[i].dv});
      check($sformatf("vec%0d_cnt", i), {5'd0, fifo_count}, {5'd0, vecs[i].cnt});
      check($sformatf("vec%0d_flags", i), {6'd0, frame_err, overrun_err},
            {6'd0, vecs[i].fe, vecs[i].oe});
    end

    // Bad stop bit, then a clean byte, then clear.
    send_byte(8'h5A, 1'b0, 1'b0);
    check("bad_stop_fe", {7'd0, frame_err}, 8'h01);
    check("bad_stop_cnt", {5'd0, fifo_count}, 8'h00);
    send_byte(8'h33, 1'b1, 1'b0);
    check("after_fe_data", data, 8'h33);
    idle(1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("err_clr_fe", {7'd0, frame_err}, 8'h00);

    // Overrun on the fifth byte.
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, 1'b0);
    check("ovr_cnt", {5'd0, fifo_count}, 8'h04);
    check("ovr_flag", {7'd0, overrun_err}, 8'h01);
    check("ovr_head", data, 8'h01);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    drain_expect(exp);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Push into a full FIFO alongside a pop.
    for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b), 1'b1, 1'b0);
    send_bits(8'h77, 8, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("full_pop_oe", {7'd0, overrun_err}, 8'h00);
    check("full_pop_cnt", {5'd0, fifo_count}, 8'h04);
    exp = '{8'h11, 8'h12, 8'h13, 8'h77};
    drain_expect(exp);

    // Rx_Enable drop mid-frame.
    send_bits(8'hFF, 3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    check("en_cnt", {5'd0, fifo_count}, 8'h01);
    check("en_data", data, 8'h3C);
    check("en_flags", {6'd0, frame_err, overrun_err}, 8'h00);
    idle(1'b1);

    // Missing stop strobe: ninth bit starts a new frame.
    send_bits(8'hFF, 8, 1'b0);
    send_byte(8'h42, 1'b1, 1'b0);
    check("nostop_fe", {7'd0, frame_err}, 8'h01);
    check("nostop_data", data, 8'h42);
    idle(1'b1);

    // Short frame coinciding with Err_Clr: set wins.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_bits(8'h03, 2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("set_wins_fe", {7'd0, frame_err}, 8'h01);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("clr_alone_fe", {7'd0, frame_err}, 8'h00);

    // Reset mid-frame with two bytes queued.
    send_byte(8'hC1, 1'b1, 1'b0);
    send_byte(8'hC2, 1'b1, 1'b0);
    send_bits(8'h0F, 4, 1'b0);
    rst_n = 1'b0;
    idle(1'b0);
    check("rst_mid_all", {data_valid, fifo_count, frame_err, overrun_err, 2'b00}, 8'h00);
    check("rst_mid_data", data, 8'h00);
    rst_n = 1'b1;
    send_byte(8'h81, 1'b1, 1'b0);
    check("post_rst_data", data, 8'h81);
    idle(1'b1);

    // Random whole frames with random stop bits and consumer.
    for (int n = 0; n < 60; n++) begin
      send_byte(8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
      if ($urandom_range(0, 7) == 0) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end

    // Random strobes, including illegal coincidences and enable drops.
    for (int n = 0; n < 2000; n++) begin
      step(1'($urandom), ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
